// File: rtl/gray_updown_counter_pkg.sv
// -----------------------------------------------------------------------------
// gray_pkg
// Shared helpers for Gray-coded counters and pointer synchronisers.
//   bin2gray / gray2bin : conversions on values up to MAX_W bits. Narrower
//                         values are passed zero-extended, which leaves the
//                         result correct for any width 1..MAX_W.
//   MODE_WRAP / MODE_SAT: encodings for the counter's SATURATE parameter.
// -----------------------------------------------------------------------------
package gray_pkg;

    localparam int unsigned MAX_W     = 32;
    localparam int unsigned MODE_WRAP = 0;
    localparam int unsigned MODE_SAT  = 1;

    function automatic logic [MAX_W-1:0] bin2gray(input logic [MAX_W-1:0] b);
        return b ^ (b >> 1);
    endfunction

    // Each binary bit is the XOR of all Gray bits at or above it.
    function automatic logic [MAX_W-1:0] gray2bin(input logic [MAX_W-1:0] g);
        logic [MAX_W-1:0] b;
        b[MAX_W-1] = g[MAX_W-1];
        for (int i = MAX_W - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

endpackage

// File: rtl/gray_updown_counter_if.sv
// -----------------------------------------------------------------------------
// gray_updown_counter_if
// Control and count bus of the Gray up/down counter.
//   clr, load, load_gray, enable, up : controls into the counter
//   bin_count, gray_count, tc        : registered results out of the counter
// master = the block driving controls; slave = the counter itself.
// -----------------------------------------------------------------------------
interface gray_updown_counter_if #(
    parameter int unsigned WIDTH = 4
);
    logic             clr;
    logic             load;
    logic [WIDTH-1:0] load_gray;
    logic             enable;
    logic             up;
    logic [WIDTH-1:0] bin_count;
    logic [WIDTH-1:0] gray_count;
    logic             tc;

    modport master (
        output clr, load, load_gray, enable, up,
        input  bin_count, gray_count, tc
    );

    modport slave (
        input  clr, load, load_gray, enable, up,
        output bin_count, gray_count, tc
    );
endinterface

// File: rtl/gray_updown_counter_gray2bin_dec.sv
// -----------------------------------------------------------------------------
// gray2bin_dec
// Purely combinational Gray-to-binary decoder (XOR prefix from the MSB down).
//   i_gray : Gray-coded input, WIDTH bits
//   o_bin  : binary equivalent, WIDTH bits
// -----------------------------------------------------------------------------
module gray2bin_dec #(
    parameter int unsigned WIDTH = 4
) (
    input  logic [WIDTH-1:0] i_gray,
    output logic [WIDTH-1:0] o_bin
);

    logic [WIDTH-1:0] w_bin;

    assign w_bin[WIDTH-1] = i_gray[WIDTH-1];

    // Ripple the XOR downward; each bit depends on the one above it.
    for (genvar i = WIDTH - 2; i >= 0; i--) begin : g_prefix
        assign w_bin[i] = w_bin[i+1] ^ i_gray[i];
    end

    assign o_bin = w_bin;

endmodule

// File: rtl/gray_updown_counter.sv
// -----------------------------------------------------------------------------
// gray_updown_counter
// Up/down counter whose Gray output comes straight from a flop, so it can be
// sampled safely in another clock domain. Supports synchronous clear, load of
// a Gray-coded value, wrap or saturate at the endpoints, and a terminal-count
// pulse aligned with the output update that hit the endpoint.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset (loads RESET_VAL)
//   bus   : slave modport carrying clr/load/load_gray/enable/up in and
//           bin_count/gray_count/tc out
// Per-cycle priority: clr > load > enable > hold.
// WIDTH must be in 2..32.
// -----------------------------------------------------------------------------
module gray_updown_counter
    import gray_pkg::*;
#(
    parameter int unsigned      WIDTH     = 4,
    parameter int unsigned      SATURATE  = MODE_WRAP,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    gray_updown_counter_if.slave  bus
);

    localparam logic [WIDTH-1:0] ALL_ONES  = '1;
    localparam logic [MAX_W-1:0] RST_G32   = bin2gray(MAX_W'(RESET_VAL));
    localparam logic [WIDTH-1:0] RST_GRAY  = RST_G32[WIDTH-1:0];
    localparam bit               SAT_MODE  = (SATURATE == MODE_SAT);

    logic [WIDTH-1:0] r_bin;
    logic [WIDTH-1:0] r_gray;
    logic             r_tc;

    logic [WIDTH-1:0] w_load_bin;
    logic [WIDTH-1:0] w_next_bin;
    logic [WIDTH-1:0] w_next_gray;
    logic             w_next_tc;

    gray2bin_dec #(
        .WIDTH (WIDTH)
    ) u_load_dec (
        .i_gray (bus.load_gray),
        .o_bin  (w_load_bin)
    );

    always_comb begin
        w_next_bin = r_bin;
        w_next_tc  = 1'b0;
        if (bus.clr) begin
            w_next_bin = '0;
        end else if (bus.load) begin
            w_next_bin = w_load_bin;
        end else if (bus.enable) begin
            if (bus.up) begin
                if (r_bin == ALL_ONES) begin
                    // Endpoint: flag it, then either hold or wrap to zero.
                    w_next_tc  = 1'b1;
                    w_next_bin = SAT_MODE ? r_bin : '0;
                end else begin
                    w_next_bin = r_bin + 1'b1;
                end
            end else begin
                if (r_bin == '0) begin
                    w_next_tc  = 1'b1;
                    w_next_bin = SAT_MODE ? r_bin : ALL_ONES;
                end else begin
                    w_next_bin = r_bin - 1'b1;
                end
            end
        end
    end

    // Gray is computed from the next binary value so both views update on
    // the same edge and gray_count has no logic after its flop.
    assign w_next_gray = w_next_bin ^ (w_next_bin >> 1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bin  <= RESET_VAL;
            r_gray <= RST_GRAY;
            r_tc   <= 1'b0;
        end else begin
            r_bin  <= w_next_bin;
            r_gray <= w_next_gray;
            r_tc   <= w_next_tc;
        end
    end

    assign bus.bin_count  = r_bin;
    assign bus.gray_count = r_gray;
    assign bus.tc         = r_tc;

endmodule

// File: tb/tb_gray_updown_counter.sv
// -----------------------------------------------------------------------------
// tb_gray_updown_counter
// Drives a wrapping counter (RESET_VAL = 5) and a saturating counter
// (RESET_VAL = 0) with identical stimulus and compares both against a
// behavioural model of the counting rules.
// -----------------------------------------------------------------------------
module tb_gray_updown_counter;

    logic clk;
    logic rst_n;

    int checks;
    int errors;

    gray_updown_counter_if #(.WIDTH(4)) bw ();
    gray_updown_counter_if #(.WIDTH(4)) bs ();

    gray_updown_counter #(
        .WIDTH     (4),
        .SATURATE  (0),
        .RESET_VAL (4'd5)
    ) dut_w (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bw)
    );

    gray_updown_counter #(
        .WIDTH     (4),
        .SATURATE  (1),
        .RESET_VAL (4'd0)
    ) dut_s (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bs)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model state: index 0 = wrapping counter, index 1 = saturating counter.
    int unsigned m_bin [2];
    bit          m_tc  [2];
    int unsigned m_rst [2] = '{5, 0};
    bit          m_sat [2] = '{1'b0, 1'b1};

    // Gray code as defined: value XOR value shifted right by one.
    function automatic int unsigned to_gray(input int unsigned v);
        return (v ^ (v >> 1)) & 15;
    endfunction

    // Find the binary value whose Gray code matches g (search, not XOR chain).
    function automatic int unsigned from_gray(input int unsigned g);
        for (int unsigned v = 0; v < 16; v++) begin
            if (to_gray(v) == g) return v;
        end
        return 0;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_bin[k] = m_rst[k];
            m_tc[k]  = 1'b0;
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, "_w_bin"},  32'(bw.bin_count),  m_bin[0]);
        chk({tag, "_w_gray"}, 32'(bw.gray_count), to_gray(m_bin[0]));
        chk({tag, "_w_tc"},   32'(bw.tc),         32'(m_tc[0]));
        chk({tag, "_s_bin"},  32'(bs.bin_count),  m_bin[1]);
        chk({tag, "_s_gray"}, 32'(bs.gray_count), to_gray(m_bin[1]));
        chk({tag, "_s_tc"},   32'(bs.tc),         32'(m_tc[1]));
    endtask

    task automatic step(input bit c, input bit l, input logic [3:0] g,
                        input bit e, input bit u, input string tag);
        logic [3:0]  pg [2];
        int unsigned pb [2];
        pg[0] = bw.gray_count;
        pg[1] = bs.gray_count;
        bw.clr = c; bw.load = l; bw.load_gray = g; bw.enable = e; bw.up = u;
        bs.clr = c; bs.load = l; bs.load_gray = g; bs.enable = e; bs.up = u;
        @(posedge clk);
        for (int k = 0; k < 2; k++) begin
            pb[k]   = m_bin[k];
            m_tc[k] = 1'b0;
            if (c) begin
                m_bin[k] = 0;
            end else if (l) begin
                m_bin[k] = from_gray(int'(g));
            end else if (e) begin
                if (u) begin
                    if (m_bin[k] == 15) begin
                        m_tc[k]  = 1'b1;
                        m_bin[k] = m_sat[k] ? 15 : 0;
                    end else begin
                        m_bin[k] = m_bin[k] + 1;
                    end
                end else begin
                    if (m_bin[k] == 0) begin
                        m_tc[k]  = 1'b1;
                        m_bin[k] = m_sat[k] ? 0 : 15;
                    end else begin
                        m_bin[k] = m_bin[k] - 1;
                    end
                end
            end
        end
        #1;
        check_all(tag);
        if (!c && !l && e) begin
            chk({tag, "_w_onebit"}, $countones(pg[0] ^ bw.gray_count),
                (pb[0] != m_bin[0]) ? 1 : 0);
            chk({tag, "_s_onebit"}, $countones(pg[1] ^ bs.gray_count),
                (pb[1] != m_bin[1]) ? 1 : 0);
        end
    endtask

    logic [3:0] seq [17] = '{4'h0, 4'h1, 4'h3, 4'h2, 4'h6, 4'h7, 4'h5, 4'h4,
                             4'hC, 4'hD, 4'hF, 4'hE, 4'hA, 4'hB, 4'h9, 4'h8, 4'h0};

    initial begin
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        bw.clr = 0; bw.load = 0; bw.load_gray = '0; bw.enable = 0; bw.up = 0;
        bs.clr = 0; bs.load = 0; bs.load_gray = '0; bs.enable = 0; bs.up = 0;
        model_reset();
        #12;
        check_all("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Hold with nothing asserted keeps reset values.
        step(0, 0, 4'h0, 0, 1, "idle");

        // Full up count from zero; wrap on 8 -> 0.
        step(1, 0, 4'h0, 0, 0, "clr0");
        for (int i = 0; i < 16; i++) begin
            step(0, 0, 4'h0, 1, 1, "up16");
            chk("seq_gray", 32'(bw.gray_count), 32'(seq[i+1]));
            chk("seq_tc",   32'(bw.tc), (i == 15) ? 1 : 0);
        end

        // Count down from zero: wrap to F / hold at 0.
        step(1, 0, 4'h0, 0, 0, "clr1");
        step(0, 0, 4'h0, 1, 0, "down0");
        chk("down_wrap_gray", 32'(bw.gray_count), 32'h8);
        step(0, 0, 4'h0, 1, 0, "down1");
        chk("down_next_gray", 32'(bw.gray_count), 32'h9);

        // Load F (Gray 8), then push up three times against the endpoint.
        step(0, 1, 4'h8, 0, 0, "loadF");
        for (int i = 0; i < 3; i++) begin
            step(0, 0, 4'h0, 1, 1, "satup");
            chk("sat_hold_gray", 32'(bs.gray_count), 32'h8);
            chk("sat_hold_tc",   32'(bs.tc), 32'h1);
        end

        // Load beats enable; then one step up.
        step(0, 1, 4'hD, 1, 1, "loadD");
        chk("loadD_bin", 32'(bw.bin_count), 32'h9);
        step(0, 0, 4'h0, 1, 1, "afterload");
        chk("afterload_gray", 32'(bw.gray_count), 32'hF);

        // clr beats load and enable.
        step(0, 1, 4'h4, 0, 0, "load7");
        step(1, 1, 4'hD, 1, 1, "clrall");
        chk("clrall_bin", 32'(bw.bin_count), 32'h0);

        // Direction reversals back to back.
        step(0, 0, 4'h0, 1, 0, "rev0");
        step(0, 0, 4'h0, 1, 1, "rev1");
        step(0, 0, 4'h0, 1, 0, "rev2");

        // Randomised traffic.
        for (int i = 0; i < 300; i++) begin
            step(($urandom_range(0, 15) == 0), ($urandom_range(0, 7) == 0),
                 4'($urandom_range(0, 15)), ($urandom_range(0, 3) != 0),
                 1'($urandom_range(0, 1)), "rand");
        end

        // Asynchronous reset in the middle of a cycle while counting at C.
        step(0, 1, 4'hA, 0, 0, "loadC");
        step(0, 0, 4'h0, 1, 1, "toD");
        step(0, 0, 4'h0, 1, 0, "backC");
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all("async_rst");
        chk("async_rst_w_gray", 32'(bw.gray_count), 32'h7);
        @(negedge clk);
        rst_n = 1'b1;
        step(0, 0, 4'h0, 1, 1, "resume");
        chk("resume_w_bin", 32'(bw.bin_count), 32'h6);

        step(0, 0, 4'h0, 0, 0, "final_idle");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/gray_updown_counter.md
Name: gray_updown_counter

Overview:
Parametrised up/down Gray-code counter with registered, glitch-free Gray output. It is the safe source for multi-bit values crossing clock domains (FIFO pointers, position counters). It adds the following:
- direction control
- synchronous clear
- synchronous load of a Gray-coded value
- wrap or saturate mode
- a terminal-count pulse

Binary and Gray views are always mutually consistent in the same cycle.

Parameters:
WIDTH, 4, counter width in bits; legal range 2..32.
SATURATE, 0, 0 = wrap modulo 2^WIDTH; 1 = hold at endpoint (all-ones when counting up, zero when counting down).
RESET_VAL, 0, binary value loaded at reset; its Gray form appears on gray_count.

Ports:
clk  input  1  rising-edge clock.
rst_n  input  1  asynchronous, active-low reset.
clr  input  1  synchronous clear to binary 0.
load  input  1  synchronous load of load_gray.
load_gray  input  WIDTH  value to load, Gray-coded.
enable  input  1  count-step enable; must be synchronous to clk.
up  input  1  direction: 1 = increment, 0 = decrement.
bin_count  output  WIDTH  registered binary count.
gray_count  output  WIDTH  registered Gray count, equal to bin_count ^ (bin_count >> 1).
tc  output  1  registered one-cycle terminal-count pulse.

Behaviour:
- Reset (rst_n low, asynchronous):
  - bin_count = RESET_VAL
  - gray_count = RESET_VAL ^ (RESET_VAL >> 1)
  - tc = 0
  - Reset mid-count aborts immediately. No pending step survives.
- Priority per cycle: clr > load > enable > hold. All operations are synchronous to clk.
- clr: next bin = 0, tc = 0. Load and enable in the same cycle are ignored.
- load: next bin = gray2bin(load_gray), tc = 0. Enable in the same cycle is ignored. The loaded value is visible on both outputs one cycle after the load edge.
- gray2bin rule: b[WIDTH-1] = g[WIDTH-1]; b[i] = b[i+1] ^ g[i].
- enable with up = 1:
  - bin < all-ones: bin + 1.
  - bin == all-ones, SATURATE = 0: wraps to 0, tc = 1 for one cycle.
  - bin == all-ones, SATURATE = 1: holds, tc = 1 for one cycle.
- enable with up = 0:
  - bin > 0: bin - 1.
  - bin == 0, SATURATE = 0: wraps to all-ones, tc = 1 for one cycle.
  - bin == 0, SATURATE = 1: holds, tc = 1 for one cycle.
- enable = 0 (and no clr/load): registers hold, tc = 0.
- Latency: one clock from enable/load/clr to the updated outputs. tc is aligned with the output update that caused it.
- Gray output is driven straight from a flop: gray_count <= bin2gray(next_bin) on the same edge as bin_count. No combinational logic sits on gray_count.
- Single-bit-change guarantee: any enabled step, including wrap in either direction, changes exactly one bit of gray_count. A saturate hold changes 0 bits. clr and load carry no such guarantee.
- Direction reversal between consecutive steps is legal with no penalty.
- All arithmetic is modulo 2^WIDTH. Carries beyond WIDTH are discarded.

Decomposition:
- Package gray_pkg holds:
  - functions bin2gray and gray2bin, parametrised by width
  - localparam-style constants for mode encoding (MODE_WRAP = 0, MODE_SAT = 1)
- Sub-module gray2bin_dec (parameter WIDTH) is the combinational XOR-prefix decoder used on load_gray. It is reused later by FIFO pointer synchronisers.
- bin2gray stays inline as a single XOR.

Test Plan:
- WIDTH = 4, reset released, enable = 1, up = 1 for 16 cycles:
  - gray_count sequence 0,1,3,2,6,7,5,4,C,D,F,E,A,B,9,8,0.
  - tc pulses only on the 8->0 cycle.
  - Checker confirms exactly one bit changes per step.
- Count down from 0 (SATURATE = 0): bin 0->F, gray 0->8, tc = 1 for one cycle; next step bin E, gray 9.
- SATURATE = 1:
  - At bin F, up with enable held 3 cycles: bin stays F, gray stays 8, tc = 1 on each blocked cycle.
  - At bin 0, down: stays 0, tc = 1.
- load = 1, load_gray = D, enable = 1 in the same cycle: next cycle bin = 9, gray = D, tc = 0. The following enabled up step gives bin A, gray F.
- clr, load and enable all asserted at bin 7: next cycle bin = 0, gray = 0.
- RESET_VAL = 5, assert rst_n low mid-count at bin C: outputs go to bin 5, gray 7, tc = 0 immediately without waiting for clk. Counting resumes from 5 after release.
